// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all input patterns through a netlist and streams (input, response) pairs with a signature
module truth_table_sweeper #(
  parameter int N_IN          = 4,
  parameter int N_OUT         = 15,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  dut_x,
  input  logic [N_OUT-1:0] dut_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  out_vec,
  output logic [N_OUT-1:0] out_resp,
  output logic [N_OUT-1:0] signature
);
  typedef enum logic [1:0] {IDLE, SETTLE, EMIT, DONE} state_t;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, out_valid_q, out_valid_d;
  logic [N_IN-1:0] dut_x_q, dut_x_d, out_vec_q, out_vec_d;
  logic [N_OUT-1:0] out_resp_q, out_resp_d, signature_q, signature_d;
  // next state: abort wins over everything; the final pattern parks in DONE instead of wrapping
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = done_q;
    out_valid_d = out_valid_q;
    dut_x_d = dut_x_q;
    out_vec_d = out_vec_q;
    out_resp_d = out_resp_q;
    signature_d = signature_q;
    if (abort) begin
      state_d = IDLE;
      done_d = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          dut_x_d = '0;
          signature_d = '0;
          done_d = 1'b0;
          cnt_d = '0;
          state_d = SETTLE;
        end
        SETTLE: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            out_resp_d = dut_f;
            out_vec_d = dut_x_q;
            out_valid_d = 1'b1;
            state_d = EMIT;
          end
        end
        EMIT: if (out_valid_q && out_ready) begin
          signature_d = ((signature_q << 1) | (signature_q >> (N_OUT - 1))) ^ out_resp_q;
          out_valid_d = 1'b0;
          if (&dut_x_q) begin
            state_d = DONE;
            done_d = 1'b1;
          end else begin
            dut_x_d = dut_x_q + N_IN'(1);
            cnt_d = '0;
            state_d = SETTLE;
          end
        end
      endcase
    end
    busy_d = (state_d == SETTLE) || (state_d == EMIT);
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_valid_q <= 1'b0;
      dut_x_q <= '0;
      out_vec_q <= '0;
      out_resp_q <= '0;
      signature_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      out_valid_q <= out_valid_d;
      dut_x_q <= dut_x_d;
      out_vec_q <= out_vec_d;
      out_resp_q <= out_resp_d;
      signature_q <= signature_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign out_valid = out_valid_q;
  assign dut_x = dut_x_q;
  assign out_vec = out_vec_q;
  assign out_resp = out_resp_q;
  assign signature = signature_q;
endmodule
